// File: rtl/crc32_pkg.sv
// rtl/crc32_pkg.sv - shared CRC-32 constants and the reflected byte-step function
// Purpose: Ethernet CRC-32 definitions used by the multi-channel engine.
// Contents: crc32_t type, reflected polynomial, INIT/XOROUT defaults,
//           crc32_byte(state, data_byte) advancing the LFSR by one byte, LSB first.
package crc32_pkg;

   typedef logic [31:0] crc32_t;

   localparam crc32_t CRC32_POLY_REFL = 32'hEDB88320;
   localparam crc32_t CRC32_INIT      = 32'hFFFFFFFF;
   localparam crc32_t CRC32_XOROUT    = 32'hFFFFFFFF;

   function automatic crc32_t crc32_byte(input crc32_t state, input logic [7:0] data_byte);
      crc32_t c;
      c = state ^ {24'd0, data_byte};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc32_mc_step.sv
// rtl/crc32_mc_step.sv - combinational multi-byte CRC-32 step for one beat
// Purpose: advances a CRC state across up to DATA_W/8 bytes, lane 0 first.
// Ports:
//   crc_in   in   32        starting state
//   keep     in   DATA_W/8  byte enables; only the contiguous run from lane 0 counts
//   data     in   DATA_W    beat payload, bits[7:0] = first byte
//   crc_out  out  32        state after the enabled bytes
module crc32_mc_step
   import crc32_pkg::*;
#(
   parameter int DATA_W = 16,
   localparam int KEEP_W = DATA_W / 8
) (
   input  crc32_t            crc_in,
   input  logic [KEEP_W-1:0] keep,
   input  logic [DATA_W-1:0] data,
   output crc32_t            crc_out
);

   crc32_t c;
   logic   run;

   // run drops at the first cleared keep bit, so later set bits are ignored.
   always_comb begin
      c   = crc_in;
      run = 1'b1;
      for (int i = 0; i < KEEP_W; i++) begin
         run = run & keep[i];
         if (run) begin
            c = crc32_byte(c, data[8*i +: 8]);
         end
      end
      crc_out = c;
   end

endmodule

// File: rtl/crc32_mc_stream.sv
// rtl/crc32_mc_stream.sv - time-shared multi-channel Ethernet CRC-32 stream engine
// Purpose: channel-tagged beats are registered in S1, folded into per-channel
//          running CRC state, and the final CRC is emitted on end of frame.
// Ports:
//   clk1, rst                 clock; asynchronous active-high reset
//   in_valid/in_ready         input beat handshake
//   in_ch, in_sof, in_eof     channel tag and frame delimiters
//   in_keep, in_data          byte enables (contiguous from lane 0) and payload
//   out_valid/out_ready       result handshake; result held while stalled
//   out_ch, out_crc           result channel and reflected post-XOROUT CRC
//   err_pulse                 one-cycle pulse for a dropped beat
module crc32_mc_stream
   import crc32_pkg::*;
#(
   parameter int     DATA_W = 16,
   parameter int     NUM_CH = 4,
   parameter crc32_t INIT   = CRC32_INIT,
   parameter crc32_t XOROUT = CRC32_XOROUT,
   localparam int    CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int    KEEP_W = DATA_W / 8
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CH_W-1:0]   in_ch,
   input  logic              in_sof,
   input  logic              in_eof,
   input  logic [KEEP_W-1:0] in_keep,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CH_W-1:0]   out_ch,
   output crc32_t            out_crc,
   output logic              err_pulse
);

   logic              s1_valid;
   logic [CH_W-1:0]   s1_ch;
   logic              s1_sof;
   logic              s1_eof;
   logic [KEEP_W-1:0] s1_keep;
   logic [DATA_W-1:0] s1_data;

   crc32_t            state_q [NUM_CH];
   logic [NUM_CH-1:0] open_q;

   logic              ch_ok;
   logic [CH_W-1:0]   ch_idx;
   logic              beat_ok;
   crc32_t            base_crc;
   crc32_t            next_crc;
   logic              s1_advance;
   logic              in_fire;

   generate
      if (NUM_CH == (1 << CH_W)) begin : g_ch_full
         assign ch_ok = 1'b1;
      end else begin : g_ch_part
         assign ch_ok = (int'(s1_ch) < NUM_CH);
      end
   endgenerate

   // Out-of-range tags never index the arrays; they are dropped as errors.
   assign ch_idx   = ch_ok ? s1_ch : '0;
   assign beat_ok  = ch_ok & (s1_sof | open_q[ch_idx]);
   assign base_crc = s1_sof ? INIT : state_q[ch_idx];

   crc32_mc_step #(.DATA_W(DATA_W)) u_step (
      .crc_in  (base_crc),
      .keep    (s1_keep),
      .data    (s1_data),
      .crc_out (next_crc)
   );

   // The state array is written on the same edge the beat leaves S1, so a
   // following beat on the same channel reads the updated value with no stall.
   assign s1_advance = s1_valid & ~(s1_eof & out_valid & ~out_ready);
   assign in_ready   = ~rst & (~s1_valid | s1_advance);
   assign in_fire    = in_valid & in_ready;

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_ch     <= '0;
         s1_sof    <= 1'b0;
         s1_eof    <= 1'b0;
         s1_keep   <= '0;
         s1_data   <= '0;
         open_q    <= '0;
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_crc   <= '0;
         err_pulse <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= INIT;
         end
      end else begin
         err_pulse <= 1'b0;

         if (out_valid & out_ready) begin
            out_valid <= 1'b0;
         end

         if (s1_advance) begin
            s1_valid <= 1'b0;
            if (beat_ok) begin
               state_q[ch_idx] <= next_crc;
               open_q[ch_idx]  <= ~s1_eof;
               if (s1_eof) begin
                  out_valid <= 1'b1;
                  out_ch    <= s1_ch;
                  out_crc   <= next_crc ^ XOROUT;
               end
            end else begin
               err_pulse <= 1'b1;
            end
         end

         if (in_fire) begin
            s1_valid <= 1'b1;
            s1_ch    <= in_ch;
            s1_sof   <= in_sof;
            s1_eof   <= in_eof;
            s1_keep  <= in_keep;
            s1_data  <= in_data;
         end
      end
   end

endmodule
